// File: rtl/fc2_bias_sequencer_if.sv
// Valid/ready bias-vector channel from the FC2 bias sequencer to the accumulator's bias-add stage.
interface fc2_bias_sequencer_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned LANES  = 16,
  parameter int unsigned BIAS_W = 34
);
  logic                      valid;
  logic                      ready;
  logic [LANES*BIAS_W-1:0]   data;
  logic [ADDR_W-1:0]         batch;

  modport master (output valid, output data, output batch, input ready);
  modport slave  (input valid, input data, input batch, output ready);
endinterface

// File: rtl/fc2_bias_sequencer.sv
// Walks the FC2 bias ROM one batch per handshake; hides the ROM's 1-cycle read latency.
// Optional FC2_BIAS_PREFETCH_EN: pre-reads batch 0 while idle so a sweep starts with data ready.
module fc2_bias_sequencer #(
  parameter int unsigned NUM_BATCH = 2,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned LANES     = 16,
  parameter int unsigned BIAS_W    = 34
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDR_W-1:0]        rom_aa_o,
  output logic                     rom_cena_o,
  input  logic [LANES*BIAS_W-1:0]  rom_qa_i,
  fc2_bias_sequencer_if.master     bias_io
);

  localparam int unsigned DataW = LANES * BIAS_W;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRead = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StHold = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [ADDR_W-1:0] LastBatch = ADDR_W'(NUM_BATCH - 1);

  logic [2:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [DataW-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] batch_q, batch_d;
  logic [ADDR_W-1:0] aa_q, aa_d;
  logic              cena_q, cena_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`ifdef FC2_BIAS_PREFETCH_EN
  logic              pf_q, pf_d;             // current READ/WAIT is a prefetch
  logic              pend_q, pend_d;         // start seen while prefetching
  logic              pref_valid_q, pref_valid_d;
  logic [DataW-1:0]  pref_q, pref_d;
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    batch_d = batch_q;
    aa_d    = aa_q;
    cena_d  = cena_q;
    cnt_d   = cnt_q;
`ifdef FC2_BIAS_PREFETCH_EN
    pf_d         = pf_q;
    pend_d       = pend_q;
    pref_valid_d = pref_valid_q;
    pref_d       = pref_q;
`endif
    case (state_q)
      StIdle: begin
`ifdef FC2_BIAS_PREFETCH_EN
        if (pref_valid_q) begin
          if (start_i) begin
            valid_d      = 1'b1;
            data_d       = pref_q;
            batch_d      = '0;
            busy_d       = 1'b1;
            cnt_d        = '0;
            pref_valid_d = 1'b0;
            state_d      = StHold;
          end
        end else begin
          aa_d    = '0;
          cena_d  = 1'b0;
          pf_d    = 1'b1;
          pend_d  = start_i;
          state_d = StRead;
        end
`else
        if (start_i) begin
          aa_d    = '0;
          cena_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = StRead;
        end
`endif
      end
      StRead: begin
        cena_d  = 1'b1;
        state_d = StWait;
`ifdef FC2_BIAS_PREFETCH_EN
        if (pf_q && start_i) pend_d = 1'b1;
`endif
      end
      StWait: begin
`ifdef FC2_BIAS_PREFETCH_EN
        if (pf_q) begin
          pf_d   = 1'b0;
          pend_d = 1'b0;
          if (pend_q || start_i) begin
            valid_d = 1'b1;
            data_d  = rom_qa_i;
            batch_d = '0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = StHold;
          end else begin
            pref_d       = rom_qa_i;
            pref_valid_d = 1'b1;
            state_d      = StIdle;
          end
        end else
`endif
        begin
          valid_d = 1'b1;
          data_d  = rom_qa_i;
          batch_d = cnt_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (valid_q && bias_io.ready) begin
          valid_d = 1'b0;
          if (cnt_q == LastBatch) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            aa_d    = cnt_q + ADDR_W'(1);
            cena_d  = 1'b0;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      batch_q <= '0;
      aa_q    <= '0;
      cena_q  <= 1'b1;
      cnt_q   <= '0;
`ifdef FC2_BIAS_PREFETCH_EN
      pf_q         <= 1'b0;
      pend_q       <= 1'b0;
      pref_valid_q <= 1'b0;
      pref_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      batch_q <= batch_d;
      aa_q    <= aa_d;
      cena_q  <= cena_d;
      cnt_q   <= cnt_d;
`ifdef FC2_BIAS_PREFETCH_EN
      pf_q         <= pf_d;
      pend_q       <= pend_d;
      pref_valid_q <= pref_valid_d;
      pref_q       <= pref_d;
`endif
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign rom_aa_o      = aa_q;
  assign rom_cena_o    = cena_q;
  assign bias_io.valid = valid_q;
  assign bias_io.data  = data_q;
  assign bias_io.batch = batch_q;

endmodule

// File: tb/tb_fc2_bias_sequencer.sv
// Directed bench for fc2_bias_sequencer with a registered ROM model and a vector scoreboard.
module tb_fc2_bias_sequencer;

  localparam int unsigned NB = 2;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 16 * 34;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] batch;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          busy, done;
  logic [AW-1:0] rom_aa;
  logic          rom_cena;
  logic [DW-1:0] rom_qa = '0;
  logic [DW-1:0] mem [4];

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];

  fc2_bias_sequencer_if #(.ADDR_W(AW), .LANES(16), .BIAS_W(34)) bias_if ();

  fc2_bias_sequencer #(.NUM_BATCH(NB), .ADDR_W(AW), .LANES(16), .BIAS_W(34)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .rom_aa_o   (rom_aa),
    .rom_cena_o (rom_cena),
    .rom_qa_i   (rom_qa),
    .bias_io    (bias_if.master)
  );

  always #5 clk = ~clk;

  // Registered-output ROM: data for the address sampled with cena low appears after that edge.
  always @(posedge clk) if (!rom_cena) rom_qa <= mem[rom_aa];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sweep();
    for (int b = 0; b < NB; b++) begin
      vec_t v;
      v.data  = mem[b];
      v.batch = AW'(b);
      sb.push_back(v);
    end
  endtask

  task automatic pop_check(input string tag);
    vec_t v;
    chk({tag, "_sb_nonempty"}, DW'(sb.size() != 0), DW'(1));
    if (sb.size() != 0) begin
      v = sb.pop_front();
      chk({tag, "_data"}, bias_if.data, v.data);
      chk({tag, "_batch"}, DW'(bias_if.batch), DW'(v.batch));
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 12 && !bias_if.valid; n++) tick();
    chk({tag, "_valid_wait"}, DW'(bias_if.valid), DW'(1));
  endtask

  task automatic drain(input string tag, output int vecs, output int dones);
    vecs  = 0;
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      if (bias_if.valid && bias_if.ready) begin
        vecs++;
        pop_check(tag);
      end
      tick();
      start = done;  // a start during DONE must be ignored
      if (done) dones++;
    end
    start = 1'b0;
  endtask

  initial begin
    int vecs, dones, lows;
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 17; j++) mem[w][j*32 +: 32] = $urandom;
    rstn = 1'b0;
    start = 1'b0;
    bias_if.ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_valid", DW'(bias_if.valid), DW'(0));
    chk("rst_data", bias_if.data, '0);
    chk("rst_cena", DW'(rom_cena), DW'(1));
    chk("rst_aa", DW'(rom_aa), DW'(0));
    rstn = 1'b1;

`ifdef FC2_BIAS_PREFETCH_EN
    lows = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (!rom_cena) lows++;
    end
    chk("pf_cena_lows", DW'(lows), DW'(1));
    chk("pf_idle_valid", DW'(bias_if.valid), DW'(0));
    bias_if.ready = 1'b1;
    start = 1'b1;
    push_sweep();
    tick();
    start = 1'b0;
    chk("pf_valid_k", DW'(bias_if.valid), DW'(1));
    drain("pf", vecs, dones);
    chk("pf_vecs", DW'(vecs), DW'(NB));
    chk("pf_dones", DW'(dones), DW'(1));
    chk("pf_sb_empty", DW'(sb.size()), DW'(0));
`else
    lows = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!rom_cena || busy || bias_if.valid) lows++;
    end
    chk("idle_quiet", DW'(lows), DW'(0));
    chk("idle_data", bias_if.data, '0);

    // Sweep with constant ready: cycle-exact timing.
    bias_if.ready = 1'b1;
    start = 1'b1;
    push_sweep();
    tick();  // edge k
    start = 1'b0;
    chk("k0_cena", DW'(rom_cena), DW'(0));
    chk("k0_aa", DW'(rom_aa), DW'(0));
    chk("k0_busy", DW'(busy), DW'(1));
    tick();
    chk("k1_cena", DW'(rom_cena), DW'(1));
    chk("k1_valid", DW'(bias_if.valid), DW'(0));
    tick();
    chk("k2_valid", DW'(bias_if.valid), DW'(1));
    pop_check("k2");
    tick();
    chk("k3_valid", DW'(bias_if.valid), DW'(0));
    chk("k3_cena", DW'(rom_cena), DW'(0));
    chk("k3_aa", DW'(rom_aa), DW'(1));
    tick();
    chk("k4_cena", DW'(rom_cena), DW'(1));
    tick();
    chk("k5_valid", DW'(bias_if.valid), DW'(1));
    pop_check("k5");
    tick();
    chk("k6_done", DW'(done), DW'(1));
    chk("k6_valid", DW'(bias_if.valid), DW'(0));
    chk("k6_busy", DW'(busy), DW'(1));
    tick();
    chk("k7_done", DW'(done), DW'(0));
    chk("k7_busy", DW'(busy), DW'(0));

    // Stall in HOLD for 7 cycles, with a stray start mid-sweep.
    bias_if.ready = 1'b0;
    start = 1'b1;
    push_sweep();
    tick();
    start = 1'b0;
    wait_valid("stall");
    for (int n = 0; n < 7; n++) begin
      start = (n == 3);
      tick();
      chk("stall_valid", DW'(bias_if.valid), DW'(1));
      chk("stall_data", bias_if.data, sb[0].data);
      chk("stall_batch", DW'(bias_if.batch), DW'(0));
      chk("stall_cena", DW'(rom_cena), DW'(1));
    end
    start = 1'b0;
    bias_if.ready = 1'b1;
    drain("stall", vecs, dones);
    chk("stall_vecs", DW'(vecs), DW'(NB));
    chk("stall_dones", DW'(dones), DW'(1));
    chk("stall_busy", DW'(busy), DW'(0));
    chk("stall_sb_empty", DW'(sb.size()), DW'(0));

    // Reset in HOLD of batch 1, then a fresh sweep starts at batch 0.
    bias_if.ready = 1'b0;
    start = 1'b1;
    push_sweep();
    tick();
    start = 1'b0;
    wait_valid("r_b0");
    pop_check("r_b0");
    bias_if.ready = 1'b1;
    tick();
    bias_if.ready = 1'b0;
    wait_valid("r_b1");
    chk("r_b1_batch", DW'(bias_if.batch), DW'(1));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("r_valid", DW'(bias_if.valid), DW'(0));
    chk("r_busy", DW'(busy), DW'(0));
    chk("r_done", DW'(done), DW'(0));
    chk("r_data", bias_if.data, '0);
    chk("r_batch", DW'(bias_if.batch), DW'(0));
    chk("r_aa", DW'(rom_aa), DW'(0));
    chk("r_cena", DW'(rom_cena), DW'(1));
    sb.delete();
    bias_if.ready = 1'b1;
    start = 1'b1;
    push_sweep();
    tick();
    start = 1'b0;
    wait_valid("post");
    drain("post", vecs, dones);
    chk("post_vecs", DW'(vecs), DW'(NB));
    chk("post_dones", DW'(dones), DW'(1));
    chk("post_sb_empty", DW'(sb.size()), DW'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
